// File: rtl/nbit_comparator.sv
// rtl/nbit_comparator.sv - registered N-bit magnitude comparator, unsigned or two's complement per sample
// Produces a one-hot {agreat, aless, equal} result one cycle after each valid sample.
module nbit_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             agreat,
    output logic             aless,
    output logic             equal
);

    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] flip_mask;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    logic valid_d,  valid_q;
    logic agreat_d, agreat_q;
    logic aless_d,  aless_q;
    logic equal_d,  equal_q;

    // Inverting the sign bit maps two's-complement order onto plain unsigned order,
    // so one unsigned comparator serves both modes without any subtraction.
    always_comb begin
        flip_mask = SIGN_MASK & {WIDTH{is_signed}};
        a_key     = a ^ flip_mask;
        b_key     = b ^ flip_mask;
    end

    always_comb begin
        valid_d  = in_valid;
        agreat_d = agreat_q;
        aless_d  = aless_q;
        equal_d  = equal_q;
        if (in_valid) begin
            agreat_d = (a_key > b_key);
            aless_d  = (a_key < b_key);
            equal_d  = (a == b);
        end
    end

    // Flags hold their last result across gaps; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            agreat_q <= 1'b0;
            aless_q  <= 1'b0;
            equal_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            agreat_q <= agreat_d;
            aless_q  <= aless_d;
            equal_q  <= equal_d;
        end
    end

    assign out_valid = valid_q;
    assign agreat    = agreat_q;
    assign aless     = aless_q;
    assign equal     = equal_q;

endmodule

// File: tb/tb_nbit_comparator.sv
// tb/tb_nbit_comparator.sv - scoreboard bench for nbit_comparator at WIDTH 4, 1, 8 and 32
module tb_nbit_comparator;

    logic clk;
    logic rst;

    logic       in_valid, is_signed;
    logic [3:0] a4, b4;
    logic       out_valid, agreat, aless, equal;

    logic        inv_w, sgn_w;
    logic        a1, b1;
    logic [7:0]  a8, b8;
    logic [31:0] a32, b32;
    logic        ov1, ag1, al1, eq1;
    logic        ov8, ag8, al8, eq8;
    logic        ov32, ag32, al32, eq32;

    logic [2:0] q4[$];
    logic [2:0] q1[$];
    logic [2:0] q8[$];
    logic [2:0] q32[$];
    logic [2:0] got, expv;
    int n_chk;
    int n_fail;

    nbit_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .is_signed(is_signed), .a(a4), .b(b4),
        .out_valid(out_valid), .agreat(agreat), .aless(aless), .equal(equal));
    nbit_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inv_w), .is_signed(sgn_w), .a(a1), .b(b1),
        .out_valid(ov1), .agreat(ag1), .aless(al1), .equal(eq1));
    nbit_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inv_w), .is_signed(sgn_w), .a(a8), .b(b8),
        .out_valid(ov8), .agreat(ag8), .aless(al8), .equal(eq8));
    nbit_comparator #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(inv_w), .is_signed(sgn_w), .a(a32), .b(b32),
        .out_valid(ov32), .agreat(ag32), .aless(al32), .equal(eq32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: convert to a mathematical integer, then order integers.
    function automatic logic [2:0] ref_flags(input int w, input bit s,
                                             input longint unsigned x, input longint unsigned y);
        longint vx;
        longint vy;
        vx = longint'(x);
        vy = longint'(y);
        if (s && x[w-1]) vx = vx - (longint'(1) << w);
        if (s && y[w-1]) vy = vy - (longint'(1) << w);
        return {vx > vy, vx < vy, x == y};
    endfunction

    task automatic tick4(input logic v, input logic s, input logic [3:0] x, input logic [3:0] y);
        in_valid  = v;
        is_signed = s;
        a4        = x;
        b4        = y;
        if (v && !rst) q4.push_back(ref_flags(4, s, 64'(x), 64'(y)));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_w(input logic s, input logic x1, input logic y1, input logic [7:0] x8,
                          input logic [7:0] y8, input logic [31:0] x32, input logic [31:0] y32);
        inv_w = 1'b1;
        sgn_w = s;
        a1 = x1;   b1 = y1;
        a8 = x8;   b8 = y8;
        a32 = x32; b32 = y32;
        q1.push_back(ref_flags(1, s, 64'(x1), 64'(y1)));
        q8.push_back(ref_flags(8, s, 64'(x8), 64'(y8)));
        q32.push_back(ref_flags(32, s, 64'(x32), 64'(y32)));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0; a4 = 4'd0; b4 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({out_valid, agreat, aless, equal} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got {ov,gt,lt,eq}=%b, required 0000", {out_valid, agreat, aless, equal});
        end
        tick4(1'b1, 1'b0, 4'd5, 4'd7);
        n_chk++;
        if ({out_valid, agreat, aless, equal} !== 4'b0000 || q4.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drops_sample: got {ov,gt,lt,eq}=%b queued=%0d, required 0000 and 0", {out_valid, agreat, aless, equal}, q4.size());
        end
        rst = 1'b0;
        tick4(1'b1, 1'b0, 4'd12, 4'd12);
        n_chk++;
        if (out_valid !== 1'b1 || q4.size() == 0) begin
            n_fail++;
            $display("FAIL first_after_reset: out_valid=%b queued=%0d, required 1 with a result", out_valid, q4.size());
        end else begin
            expv = q4.pop_front();
            got  = {agreat, aless, equal};
            n_chk++;
            if (got !== expv || expv !== 3'b001) begin
                n_fail++;
                $display("FAIL first_after_reset_flags: got %b, required %b", got, expv);
            end
        end
    endtask

    task automatic test_directed(input string name, input logic s, input logic [3:0] xa[4], input logic [3:0] ya[4]);
        for (int i = 0; i < 4; i++) begin
            tick4(1'b1, s, xa[i], ya[i]);
            n_chk++;
            if (out_valid !== 1'b1 || q4.size() == 0) begin
                n_fail++;
                $display("FAIL %s_valid[%0d]: out_valid=%b queued=%0d, required 1 with a result", name, i, out_valid, q4.size());
            end else begin
                expv = q4.pop_front();
                got  = {agreat, aless, equal};
                n_chk++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL %s_flags[%0d] a=%0d b=%0d: got %b, required %b", name, i, xa[i], ya[i], got, expv);
                end
            end
        end
    endtask

    task automatic test_exhaustive;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    tick4(1'b1, 1'(s), 4'(x), 4'(y));
                    n_chk++;
                    if (out_valid !== 1'b1 || q4.size() == 0) begin
                        n_fail++;
                        $display("FAIL exh_valid s=%0d a=%0d b=%0d: out_valid=%b, required 1", s, x, y, out_valid);
                    end else begin
                        expv = q4.pop_front();
                        got  = {agreat, aless, equal};
                        n_chk++;
                        if (got !== expv || $countones(got) != 1) begin
                            n_fail++;
                            $display("FAIL exh_flags s=%0d a=%0d b=%0d: got %b, required %b", s, x, y, got, expv);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_valid_gap;
        tick4(1'b1, 1'b0, 4'd10, 4'd1);
        n_chk++;
        if (out_valid !== 1'b1 || q4.size() == 0) begin
            n_fail++;
            $display("FAIL gap_valid: out_valid=%b, required 1", out_valid);
        end else begin
            expv = q4.pop_front();
            got  = {agreat, aless, equal};
            n_chk++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL gap_first_flags: got %b, required %b", got, expv);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick4(1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
            n_chk++;
            if ({out_valid, agreat, aless, equal} !== 4'b0100) begin
                n_fail++;
                $display("FAIL gap_hold[%0d]: got {ov,gt,lt,eq}=%b, required 0100", i, {out_valid, agreat, aless, equal});
            end
        end
    endtask

    task automatic test_midstream_reset;
        tick4(1'b1, 1'b0, 4'd1, 4'd2);
        n_chk++;
        if (q4.size() == 0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: out_valid=%b, required 1", out_valid);
        end else begin
            expv = q4.pop_front();
            got  = {agreat, aless, equal};
            n_chk++;
            if (got !== expv) begin
                n_fail++;
                $display("FAIL mid_pre_flags: got %b, required %b", got, expv);
            end
        end
        rst = 1'b1;
        tick4(1'b1, 1'b0, 4'd5, 4'd7);
        rst = 1'b0;
        n_chk++;
        if ({out_valid, agreat, aless, equal} !== 4'b0000 || q4.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got {ov,gt,lt,eq}=%b queued=%0d, required 0000 and 0", {out_valid, agreat, aless, equal}, q4.size());
        end
        tick4(1'b0, 1'b0, 4'd3, 4'd3);
        n_chk++;
        if ({out_valid, agreat, aless, equal} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got {ov,gt,lt,eq}=%b, required 0000", {out_valid, agreat, aless, equal});
        end
    endtask

    task automatic test_width_sweep;
        tick_w(1'b1, 1'b1, 1'b0, 8'h80, 8'h7f, 32'h8000_0000, 32'h7fff_ffff);
        for (int i = 0; i <= 10000; i++) begin
            if (i > 0) tick_w(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), $urandom, (i % 7 == 0) ? a32 : $urandom);
            n_chk += 3;
            if (!ov1 || !ov8 || !ov32 || q1.size() == 0 || q8.size() == 0 || q32.size() == 0) begin
                n_fail++;
                $display("FAIL sweep_valid[%0d]: ov1=%b ov8=%b ov32=%b, required 111", i, ov1, ov8, ov32);
                q1.delete(); q8.delete(); q32.delete();
            end else begin
                expv = q1.pop_front();
                if ({ag1, al1, eq1} !== expv || (i == 0 && expv !== 3'b010)) begin
                    n_fail++;
                    $display("FAIL sweep_w1[%0d] s=%b a=%b b=%b: got %b, required %b", i, sgn_w, a1, b1, {ag1, al1, eq1}, expv);
                end
                expv = q8.pop_front();
                if ({ag8, al8, eq8} !== expv) begin
                    n_fail++;
                    $display("FAIL sweep_w8[%0d] s=%b a=%h b=%h: got %b, required %b", i, sgn_w, a8, b8, {ag8, al8, eq8}, expv);
                end
                expv = q32.pop_front();
                if ({ag32, al32, eq32} !== expv) begin
                    n_fail++;
                    $display("FAIL sweep_w32[%0d] s=%b a=%h b=%h: got %b, required %b", i, sgn_w, a32, b32, {ag32, al32, eq32}, expv);
                end
            end
        end
        inv_w = 1'b0;
    endtask

    initial begin
        logic [3:0] ua[4];
        logic [3:0] ub[4];
        n_chk  = 0;
        n_fail = 0;
        inv_w = 1'b0; sgn_w = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'd0; b8 = 8'd0; a32 = 32'd0; b32 = 32'd0;
        test_reset;
        ua = '{4'd5, 4'd1, 4'd10, 4'd12};
        ub = '{4'd7, 4'd2, 4'd1, 4'd12};
        test_directed("unsigned", 1'b0, ua, ub);
        ua = '{4'd10, 4'd8, 4'd15, 4'd12};
        ub = '{4'd1, 4'd7, 4'd14, 4'd12};
        test_directed("signed", 1'b1, ua, ub);
        ua = '{4'd15, 4'd0, 4'd8, 4'd7};
        ub = '{4'd0, 4'd0, 4'd0, 4'd8};
        test_directed("ext_unsigned", 1'b0, ua, ub);
        test_directed("ext_signed", 1'b1, ua, ub);
        test_exhaustive;
        test_valid_gap;
        test_midstream_reset;
        test_width_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
